// File: rtl/seq_booth_mul.sv
// seq_booth_mul
// Sequential radix-4 Booth multiplier with a run-time signed/unsigned mode.
// Operands are captured when start is seen with the block idle. The product is
// built one Booth digit per cycle over N cycles on a single EW+2-bit adder.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (aborts any multiply, zeroes outputs)
//   start        request a multiply; accepted only on an edge where busy=0
//   mode_signed  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b         multiplicand / multiplier, WIDTH bits (sampled with start)
//   busy         high while iterating
//   done         one-cycle pulse: out holds a new product
//   out          2*WIDTH-bit product, held until the next completion
//
// Handshake: start behaves as a valid whose ready is ~busy. A request is taken
// on the edge where start=1 and busy=0; the matching done pulse follows N edges
// later. start, a, b and mode_signed are don't-care while busy=1. start may be
// high during the done cycle and is then accepted at once.
module seq_booth_mul #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  // Extended width is even and at least WIDTH+1. The extra bit keeps unsigned
  // operands positive when they are treated as signed.
  localparam int EW = (WIDTH % 2 != 0) ? WIDTH + 1 : WIDTH + 2;
  localparam int N  = EW / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic                load, last;
  logic [EW-1:0]       a_q;        // captured, extended multiplicand
  logic [EW:0]         m_q;        // multiplier shift register with Booth guard bit
  logic signed [EW+1:0] hi_q;      // upper half of the accumulator
  logic [EW-1:0]       lo_q;       // product bits shifted out of hi_q
  logic [CW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]  out_q;
  logic                done_q;

  logic [EW-1:0]        a_ext, b_ext;
  logic signed [EW+1:0] a_wide, pp, sum, hi_n;
  logic [EW-1:0]        lo_n;
  logic [EW:0]          m_n;
  logic [2*WIDTH-1:0]   out_d;

  assign a_ext = {{(EW-WIDTH){mode_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{(EW-WIDTH){mode_signed & b[WIDTH-1]}}, b};

  // Next-state and control.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        last = (cnt_q == CW'(N - 1));
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One Booth step: decode the digit, add it to the upper half, then shift the
  // accumulator and the multiplier right by two.
  always_comb begin
    a_wide = {{2{a_q[EW-1]}}, a_q};
    case (m_q[2:0])
      3'b001, 3'b010: pp = a_wide;
      3'b011:         pp = a_wide <<< 1;
      3'b100:         pp = -(a_wide <<< 1);
      3'b101, 3'b110: pp = -a_wide;
      default:        pp = '0;
    endcase
    sum   = hi_q + pp;
    hi_n  = sum >>> 2;
    lo_n  = {sum[1:0], lo_q[EW-1:2]};
    m_n   = {{2{m_q[EW]}}, m_q[EW:2]};
    // After N steps {hi, lo} holds the full product; keep the low 2*WIDTH bits.
    out_d = (2*WIDTH)'({hi_n, lo_n});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last;
      if (load) begin
        a_q   <= a_ext;
        m_q   <= {b_ext, 1'b0};
        hi_q  <= '0;
        lo_q  <= '0;
        cnt_q <= '0;
      end else if (state_q == BUSY) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        m_q   <= m_n;
        cnt_q <= cnt_q + 1'b1;
        if (last) out_q <= out_d;
      end
    end
  end

  assign busy = (state_q == BUSY);
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_seq_booth_mul.sv
// tb_seq_booth_mul
// Self-checking bench for seq_booth_mul at WIDTH=6, 7 and 16. Drivers push the
// expected product and the accept cycle into per-instance queues. Per-instance
// monitors pop on each done pulse and compare the product and the latency. They
// also confirm that out holds its value between completions.
module tb_seq_booth_mul;

  localparam int N6 = 4, N7 = 4, N16 = 9;
  localparam int M_DROP = 0, M_HOLD = 1, M_JUNK = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // ---------------- DUTs ----------------
  logic        start6 = 0, ms6 = 0, busy6, done6;
  logic [5:0]  a6 = 0, b6 = 0;
  logic [11:0] out6;
  logic        start7 = 0, ms7 = 0, busy7, done7;
  logic [6:0]  a7 = 0, b7 = 0;
  logic [13:0] out7;
  logic        start16 = 0, ms16 = 0, busy16, done16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] out16;

  seq_booth_mul #(.WIDTH(6)) u6 (.clk(clk), .rst(rst), .start(start6), .mode_signed(ms6),
    .a(a6), .b(b6), .busy(busy6), .done(done6), .out(out6));
  seq_booth_mul #(.WIDTH(7)) u7 (.clk(clk), .rst(rst), .start(start7), .mode_signed(ms7),
    .a(a7), .b(b7), .busy(busy7), .done(done7), .out(out7));
  seq_booth_mul #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .start(start16), .mode_signed(ms16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .out(out16));

  // ---------------- reference model ----------------
  function automatic longint ref_prod(int w, longint av, longint bv, bit ms);
    longint m, x, y;
    m = (longint'(1) << w) - 1;
    x = av & m;
    y = bv & m;
    if (ms && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    if (ms && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
    return (x * y) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [11:0] exp6_q[$];
  logic [13:0] exp7_q[$];
  logic [31:0] exp16_q[$];
  int acc6_q[$], acc7_q[$], acc16_q[$];
  longint last6 = 0, last7 = 0, last16 = 0;

  always @(negedge clk) begin
    longint e;
    int c;
    if (chk_en) begin
      if (done6) begin
        if (exp6_q.size() == 0) check("w6_unexpected_done", 1, 0);
        else begin
          e = exp6_q.pop_front();
          c = acc6_q.pop_front();
          check("w6_out", out6, e);
          check("w6_latency", cyc, c + N6);
          last6 = e;
        end
      end else check("w6_out_hold", out6, last6);
    end
  end

  always @(negedge clk) begin
    longint e;
    int c;
    if (chk_en) begin
      if (done7) begin
        if (exp7_q.size() == 0) check("w7_unexpected_done", 1, 0);
        else begin
          e = exp7_q.pop_front();
          c = acc7_q.pop_front();
          check("w7_out", out7, e);
          check("w7_latency", cyc, c + N7);
          last7 = e;
        end
      end else check("w7_out_hold", out7, last7);
    end
  end

  always @(negedge clk) begin
    longint e;
    int c;
    if (chk_en) begin
      if (done16) begin
        if (exp16_q.size() == 0) check("w16_unexpected_done", 1, 0);
        else begin
          e = exp16_q.pop_front();
          c = acc16_q.pop_front();
          check("w16_out", out16, e);
          check("w16_latency", cyc, c + N16);
          last16 = e;
        end
      end else check("w16_out_hold", out16, last16);
    end
  end

  // ---------------- driver tasks ----------------
  // Wait (bounded) for an idle cycle, then present the request so the next edge
  // accepts it. While waiting, start is dropped, held, or driven with junk.
  task automatic issue6(input longint av, input longint bv, input bit ms,
                        input logic [11:0] exp, input int mode);
    int guard = 0;
    @(negedge clk);
    while (busy6 && guard < 100) begin
      if (mode == M_JUNK) begin
        a6 = 6'($urandom); b6 = 6'($urandom); ms6 = 1'($urandom); start6 = 1'($urandom);
      end else if (mode == M_DROP) start6 = 1'b0;
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("w6_idle_timeout", guard, 0);
    a6 = av[5:0]; b6 = bv[5:0]; ms6 = ms; start6 = 1'b1;
    exp6_q.push_back(exp);
    acc6_q.push_back(cyc + 1);
  endtask

  task automatic issue7(input longint av, input longint bv, input bit ms, input logic [13:0] exp);
    int guard = 0;
    @(negedge clk);
    while (busy7 && guard < 100) begin
      start7 = 1'b0;
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("w7_idle_timeout", guard, 0);
    a7 = av[6:0]; b7 = bv[6:0]; ms7 = ms; start7 = 1'b1;
    exp7_q.push_back(exp);
    acc7_q.push_back(cyc + 1);
  endtask

  task automatic issue16(input longint av, input longint bv, input bit ms);
    int guard = 0;
    @(negedge clk);
    while (busy16 && guard < 100) begin
      start16 = 1'b0;
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("w16_idle_timeout", guard, 0);
    a16 = av[15:0]; b16 = bv[15:0]; ms16 = ms; start16 = 1'b1;
    exp16_q.push_back(32'(ref_prod(16, av, bv, ms)));
    acc16_q.push_back(cyc + 1);
  endtask

  // Stop requesting and wait (bounded) until every expected result has arrived.
  task automatic drain(input int which);
    int guard = 0;
    @(negedge clk);
    if (which == 6) start6 = 1'b0;
    if (which == 7) start7 = 1'b0;
    if (which == 16) start16 = 1'b0;
    while (guard < 50 && ((which == 6 && exp6_q.size() != 0) ||
                          (which == 7 && exp7_q.size() != 0) ||
                          (which == 16 && exp16_q.size() != 0))) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("drain_timeout", which, 0);
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy6"}, busy6, 0);
    check({tag, "_done6"}, done6, 0);
    check({tag, "_out6"}, out6, 0);
    check({tag, "_busy7"}, busy7, 0);
    check({tag, "_done7"}, done7, 0);
    check({tag, "_out7"}, out7, 0);
    check({tag, "_busy16"}, busy16, 0);
    check({tag, "_done16"}, done16, 0);
    check({tag, "_out16"}, out16, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    fork
      begin
        // Exhaustive signed and unsigned sweeps at WIDTH=6.
        for (int i = -32; i < 32; i++)
          for (int j = -32; j < 32; j++)
            issue6(i, j, 1'b1, 12'(ref_prod(6, i, j, 1'b1)), M_DROP);
        for (int i = 0; i < 64; i++)
          for (int j = 0; j < 64; j++)
            issue6(i, j, 1'b0, 12'(ref_prod(6, i, j, 1'b0)), M_DROP);
        // Directed corner products with literal expectations.
        issue6(-32, -32, 1'b1, 12'h400, M_DROP);
        issue6(-32, 31, 1'b1, 12'hC20, M_DROP);
        issue6(63, 63, 1'b0, 12'hF81, M_DROP);
        issue6(0, 63, 1'b0, 12'h000, M_DROP);
        issue6(63, 1, 1'b0, 12'h03F, M_DROP);
        // start held high across completions, then junk while busy.
        issue6(5, -3, 1'b1, 12'hFF1, M_HOLD);
        issue6(-7, 7, 1'b1, 12'hFCF, M_HOLD);
        issue6(5, -3, 1'b1, 12'hFF1, M_JUNK);
        issue6(-7, 7, 1'b1, 12'hFCF, M_JUNK);
        issue6(5, -3, 1'b1, 12'hFF1, M_JUNK);
        drain(6);
      end
      begin
        issue7(-64, -64, 1'b1, 14'h1000);
        issue7(-64, 63, 1'b1, 14'h3040);
        issue7(127, 127, 1'b0, 14'h3F01);
        for (int k = 0; k < 200; k++) begin
          longint av, bv;
          bit ms;
          av = longint'($urandom_range(0, 127));
          bv = longint'($urandom_range(0, 127));
          ms = 1'($urandom);
          issue7(av, bv, ms, 14'(ref_prod(7, av, bv, ms)));
        end
        drain(7);
      end
      begin
        issue16(-32768, -32768, 1'b1);
        issue16(-32768, 32767, 1'b1);
        issue16(65535, 65535, 1'b0);
        for (int k = 0; k < 3000; k++)
          issue16(longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)),
                  $urandom_range(0, 3) != 0);
        drain(16);
      end
    join

    // Reset in the middle of a multiply aborts it cleanly.
    issue6(31, 31, 1'b1, 12'(ref_prod(6, 31, 31, 1'b1)), M_DROP);
    @(negedge clk);
    start6 = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    exp6_q.delete(); acc6_q.delete();
    exp7_q.delete(); acc7_q.delete();
    exp16_q.delete(); acc16_q.delete();
    last6 = 0; last7 = 0; last16 = 0;
    chk_en = 1'b1;
    issue6(2, 3, 1'b1, 12'h006, M_DROP);
    drain(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
